reflet_bus_initiator: RTL and testbench

- Byte-wide system-bus initiator that drives the peripheral register bus: address, enable, write enable and write data.
- Samples the OR'd read data returned by the addressed register.
- Accepts single commands from a controller over a valid/ready handshake: read, write, read-modify-write, or poll-until-match with timeout.
- Returns one response per command. Sits between a sequencer/debug port and the peripheral register space.

---
 rtl/reflet_bus_initiator.sv | 198 +++++++++++++++++++
 tb/tb_reflet_bus_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reflet_bus_initiator.sv
// Byte-wide register-bus initiator: executes one read, write, read-modify-write
// or poll-until-match command per handshake and returns a single response.
module reflet_bus_initiator #(
    parameter int addr_size    = 16,
    parameter int poll_timeout = 255,
    parameter int poll_gap     = 0
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [addr_size-1:0] cmd_addr,
    input  logic [7:0]           cmd_wdata,
    input  logic [7:0]           cmd_mask,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic                 rsp_timeout,

    output logic                 bus_enable,
    output logic [addr_size-1:0] bus_addr,
    output logic                 bus_write_en,
    output logic [7:0]           bus_data_out,
    input  logic [7:0]           bus_data_in
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_RMW   = 2'b10;
    localparam logic [1:0] OP_POLL  = 2'b11;

    localparam logic [16:0] POLL_LIMIT = 17'(poll_timeout);
    localparam logic [7:0]  GAP_LAST   = (poll_gap > 0) ? 8'(poll_gap - 1) : 8'd0;
    localparam bit          HAS_GAP    = (poll_gap > 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RMW_WR = 3'd2,
        GAP    = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [addr_size-1:0]  addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [7:0]            mask_q, mask_d;
    logic [7:0]            old_q, old_d;
    logic [15:0]           poll_cnt_q, poll_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [7:0]            rsp_data_q, rsp_data_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [7:0]            rmw_value;
    logic                  poll_hit;
    logic [16:0]           poll_cnt_inc;

    assign rmw_value    = (old_q & ~mask_q) | (wdata_q & mask_q);
    assign poll_hit     = ((bus_data_in ^ wdata_q) & mask_q) == 8'h00;
    // One bit wider than the counter so the limit compare can never wrap.
    assign poll_cnt_inc = {1'b0, poll_cnt_q} + 17'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            op_q          <= 2'b00;
            addr_q        <= '0;
            wdata_q       <= 8'h00;
            mask_q        <= 8'h00;
            old_q         <= 8'h00;
            poll_cnt_q    <= 16'h0000;
            gap_cnt_q     <= 8'h00;
            rsp_data_q    <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            mask_q        <= mask_d;
            old_q         <= old_d;
            poll_cnt_q    <= poll_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        mask_d        = mask_q;
        old_d         = old_q;
        poll_cnt_d    = poll_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;

        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        bus_enable    = 1'b0;
        bus_addr      = '0;
        bus_write_en  = 1'b0;
        bus_data_out  = 8'h00;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d          = cmd_op;
                    addr_d        = cmd_addr;
                    wdata_d       = cmd_wdata;
                    mask_d        = cmd_mask;
                    poll_cnt_d    = 16'h0000;
                    gap_cnt_d     = 8'h00;
                    rsp_timeout_d = 1'b0;
                    state_d       = ACCESS;
                end
            end

            ACCESS: begin
                bus_enable = 1'b1;
                bus_addr   = addr_q;
                case (op_q)
                    OP_READ: begin
                        rsp_data_d = bus_data_in;
                        state_d    = RESP;
                    end
                    OP_WRITE: begin
                        bus_write_en = 1'b1;
                        bus_data_out = wdata_q;
                        rsp_data_d   = wdata_q;
                        state_d      = RESP;
                    end
                    OP_RMW: begin
                        old_d   = bus_data_in;
                        state_d = RMW_WR;
                    end
                    OP_POLL: begin
                        rsp_data_d = bus_data_in;
                        // A match wins even on the read that exhausts the budget.
                        if (poll_hit) begin
                            rsp_timeout_d = 1'b0;
                            state_d       = RESP;
                        end else begin
                            poll_cnt_d = poll_cnt_inc[15:0];
                            if (poll_cnt_inc == POLL_LIMIT) begin
                                rsp_timeout_d = 1'b1;
                                state_d       = RESP;
                            end else if (HAS_GAP) begin
                                gap_cnt_d = 8'h00;
                                state_d   = GAP;
                            end
                        end
                    end
                    default: state_d = RESP;
                endcase
            end

            RMW_WR: begin
                bus_enable   = 1'b1;
                bus_addr     = addr_q;
                bus_write_en = 1'b1;
                bus_data_out = rmw_value;
                rsp_data_d   = rmw_value;
                state_d      = RESP;
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 8'h00;
                    state_d   = ACCESS;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end

            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_reflet_bus_initiator.sv
// Directed bench for reflet_bus_initiator: a register-file model answers the bus,
// expected bus cycles and responses are queued and checked by negedge monitors.
module tb_reflet_bus_initiator;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_mask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_timeout;
    logic        bus_enable;
    logic [15:0] bus_addr;
    logic        bus_write_en;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;

    always #5 clk = ~clk;

    reflet_bus_initiator #(
        .addr_size   (16),
        .poll_timeout(4),
        .poll_gap    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .bus_enable  (bus_enable),
        .bus_addr    (bus_addr),
        .bus_write_en(bus_write_en),
        .bus_data_out(bus_data_out),
        .bus_data_in (bus_data_in)
    );

    // Register file model; 0x20 turns 0x80 on its 3rd read, 0x21 on its 4th.
    logic [7:0] mem [0:255];
    int         reads_20;
    int         reads_21;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'h5A;
            mem[8'h12] <= 8'hF0;
            mem[8'h13] <= 8'h55;
            reads_20   <= 0;
            reads_21   <= 0;
        end else if (bus_enable) begin
            if (bus_write_en) mem[bus_addr[7:0]] <= bus_data_out;
            else if (bus_addr == 16'h0020) reads_20 <= reads_20 + 1;
            else if (bus_addr == 16'h0021) reads_21 <= reads_21 + 1;
        end
    end

    always_comb begin
        bus_data_in = 8'h00;
        if (bus_enable && !bus_write_en) begin
            case (bus_addr)
                16'h0020: bus_data_in = (reads_20 >= 2) ? 8'h80 : 8'h00;
                16'h0021: bus_data_in = (reads_21 >= 3) ? 8'h80 : 8'h00;
                default:  bus_data_in = mem[bus_addr[7:0]];
            endcase
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       tmo;
    } rsp_t;
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_t;

    rsp_t rsp_q[$];
    bus_t bus_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: every enabled cycle must match the next expected bus cycle.
    always @(negedge clk) begin
        bus_t eb;
        if (bus_enable) begin
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_cycle_addr", 32'(bus_addr), 32'hFFFF_FFFF);
            end else begin
                eb = bus_q.pop_front();
                chk("bus_write_en", 32'(bus_write_en), 32'(eb.we));
                chk("bus_addr", 32'(bus_addr), 32'(eb.addr));
                if (eb.we) chk("bus_data_out", 32'(bus_data_out), 32'(eb.data));
            end
        end else begin
            chk("bus_idle_outputs", {15'd0, bus_write_en, bus_addr}, 32'd0);
            chk("bus_idle_data", 32'(bus_data_out), 32'd0);
        end
    end

    // Response monitor: pops on every handshake.
    always @(negedge clk) begin
        rsp_t er;
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected_data", 32'(rsp_data), 32'hFFFF_FFFF);
            end else begin
                er = rsp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(er.data));
                chk("rsp_timeout", 32'(rsp_timeout), 32'(er.tmo));
            end
        end
    end

    task automatic exp_bus(input logic we, input logic [15:0] addr, input logic [7:0] data);
        bus_t b;
        b.we = we; b.addr = addr; b.data = data;
        bus_q.push_back(b);
    endtask

    task automatic exp_rsp(input logic [7:0] data, input logic tmo);
        rsp_t r;
        r.data = data; r.tmo = tmo;
        rsp_q.push_back(r);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] mask);
        logic took;
        took      = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_mask  = mask;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                took = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 32'(took), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        cmd_mask  = 8'h00;
    endtask

    // Counts negedges after the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input int exp_lat, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 64);
        chk(name, 32'(n), 32'(exp_lat));
    endtask

    task automatic finish_rsp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 16'h0000;
        cmd_wdata = 8'h00;
        cmd_mask  = 8'h00;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Read 0x0010 -> 0x5A
        exp_bus(1'b0, 16'h0010, 8'h00); exp_rsp(8'h5A, 1'b0);
        send(2'b00, 16'h0010, 8'h00, 8'hFF);
        wait_rsp(2, "lat_read"); finish_rsp();
        $display("read  0x0010 -> %02h", rsp_data);

        // Write 0x0011 <- 0xC3, non-zero mask must be ignored
        exp_bus(1'b1, 16'h0011, 8'hC3); exp_rsp(8'hC3, 1'b0);
        send(2'b01, 16'h0011, 8'hC3, 8'h0F);
        wait_rsp(2, "lat_write"); finish_rsp();
        chk("reg_0011_written", 32'(mem[8'h11]), 32'h0000_00C3);
        $display("write 0x0011 <- %02h", rsp_data);

        exp_bus(1'b0, 16'h0011, 8'h00); exp_rsp(8'hC3, 1'b0);
        send(2'b00, 16'h0011, 8'h00, 8'h00);
        wait_rsp(2, "lat_readback"); finish_rsp();
        $display("read  0x0011 -> %02h", rsp_data);

        // RMW 0x0012: 0xF0 with wdata 0x0F mask 0x3C -> 0xCC
        exp_bus(1'b0, 16'h0012, 8'h00); exp_bus(1'b1, 16'h0012, 8'hCC); exp_rsp(8'hCC, 1'b0);
        send(2'b10, 16'h0012, 8'h0F, 8'h3C);
        wait_rsp(3, "lat_rmw"); finish_rsp();
        chk("reg_0012_rmw", 32'(mem[8'h12]), 32'h0000_00CC);
        $display("rmw   0x0012 -> %02h", rsp_data);

        // Poll 0x0020, match on 3rd read: 3 reads + 4 gap cycles
        repeat (3) exp_bus(1'b0, 16'h0020, 8'h00);
        exp_rsp(8'h80, 1'b0);
        send(2'b11, 16'h0020, 8'h80, 8'h80);
        wait_rsp(8, "lat_poll_match"); finish_rsp();
        $display("poll  0x0020 -> %02h tmo %0b", rsp_data, rsp_timeout);

        // Poll 0x0021, match on the 4th (last allowed) read: no timeout
        repeat (4) exp_bus(1'b0, 16'h0021, 8'h00);
        exp_rsp(8'h80, 1'b0);
        send(2'b11, 16'h0021, 8'h80, 8'h80);
        wait_rsp(11, "lat_poll_limit_match"); finish_rsp();
        $display("poll  0x0021 -> %02h tmo %0b", rsp_data, rsp_timeout);

        // Poll stuck register: exactly 4 reads, then timeout
        repeat (4) exp_bus(1'b0, 16'h0030, 8'h00);
        exp_rsp(8'h00, 1'b1);
        send(2'b11, 16'h0030, 8'h80, 8'h80);
        wait_rsp(11, "lat_poll_timeout"); finish_rsp();
        chk("tmo_held_in_idle", 32'(rsp_timeout), 32'd1);
        $display("poll  0x0030 -> %02h tmo %0b", rsp_data, rsp_timeout);

        exp_bus(1'b0, 16'h0010, 8'h00); exp_rsp(8'h5A, 1'b0);
        send(2'b00, 16'h0010, 8'h00, 8'h00);
        chk("tmo_cleared_on_accept", 32'(rsp_timeout), 32'd0);
        wait_rsp(2, "lat_read_after_tmo"); finish_rsp();
        $display("read  0x0010 -> %02h tmo %0b", rsp_data, rsp_timeout);

        // Backpressure: response held, competing command ignored
        rsp_ready = 1'b0;
        exp_bus(1'b0, 16'h0010, 8'h00); exp_rsp(8'h5A, 1'b0);
        send(2'b00, 16'h0010, 8'h00, 8'h00);
        wait_rsp(2, "lat_backpressure");
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 16'h0015;
        cmd_wdata = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_rsp_data", 32'(rsp_data), 32'h0000_005A);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        finish_rsp();
        chk("bp_no_write_0015", 32'(mem[8'h15]), 32'd0);
        $display("backpressure read 0x0010 -> %02h", rsp_data);

        // Reset during the RMW read cycle: no write, no response
        exp_bus(1'b0, 16'h0013, 8'h00);
        send(2'b10, 16'h0013, 8'hFF, 8'hFF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_bus_enable", 32'(bus_enable), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_mid_rsp_valid_later", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        $display("reset during rmw: rsp_valid %0b cmd_ready %0b", rsp_valid, cmd_ready);

        exp_bus(1'b0, 16'h0013, 8'h00); exp_rsp(8'h55, 1'b0);
        send(2'b00, 16'h0013, 8'h00, 8'h00);
        wait_rsp(2, "lat_read_after_reset"); finish_rsp();
        $display("read  0x0013 -> %02h", rsp_data);

        repeat (4) @(negedge clk);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
